// File: rtl/usbd_hid_report_responder.sv
// usbd_hid_report_responder
// Transaction engine for one interrupt IN endpoint of a low/full-speed USB HID
// device. It decodes IN tokens arriving from a byte-level PHY/SIE and answers
// with DATA0/DATA1 + report + CRC16, or NAK. The host ACK drives the data toggle.
module usbd_hid_report_responder #(
  parameter int C_report_length = 8,
  parameter int C_endpoint      = 1,
  parameter int C_ack_timeout   = 255
) (
  input  logic                         clk,
  input  logic                         bus_reset,
  input  logic [6:0]                   dev_addr,
  input  logic [C_report_length*8-1:0] report,
  input  logic                         report_strobe,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         rx_active,
  input  logic                         rx_error,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  output logic                         tx_last,
  input  logic                         tx_ready,
  output logic                         toggle,
  output logic                         pending,
  output logic                         sent
);

  localparam int W_IDX = (C_report_length > 1) ? $clog2(C_report_length) : 1;
  localparam int W_CNT = (C_ack_timeout > 0) ? $clog2(C_ack_timeout + 1) : 1;
  localparam logic [W_IDX-1:0] C_LAST_IDX = W_IDX'(C_report_length - 1);
  localparam logic [W_CNT-1:0] C_CNT_LOAD = W_CNT'(C_ack_timeout);
  localparam logic [3:0]       C_EP       = 4'(C_endpoint);

  localparam logic [7:0] C_PID_IN    = 8'h69;
  localparam logic [7:0] C_PID_DATA0 = 8'hC3;
  localparam logic [7:0] C_PID_DATA1 = 8'h4B;
  localparam logic [7:0] C_PID_ACK   = 8'hD2;
  localparam logic [7:0] C_PID_NAK   = 8'h5A;

  // The PID byte is evaluated directly in IDLE, so TOK1 already means
  // "valid IN PID seen, waiting for the first token byte".
  typedef enum logic [3:0] {
    S_IDLE,
    S_TOK1,
    S_TOK2,
    S_TOK_END,
    S_SKIP,
    S_TX_PID,
    S_TX_DATA,
    S_TX_CRCL,
    S_TX_CRCH,
    S_TX_HS,
    S_WAIT_ACK,
    S_ACK_END
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [7:0]                   r_b1;
  logic [7:0]                   r_b2;
  logic [C_report_length*8-1:0] r_stage;
  logic                         r_staged;
  logic [C_report_length*8-1:0] r_active;
  logic                         r_pending;
  logic                         r_toggle;
  logic [W_IDX-1:0]             r_idx;
  logic [15:0]                  r_crc;
  logic [W_CNT-1:0]             r_cnt;

  logic                         w_ack_done;
  logic                         w_copy;
  logic                         w_tok_ok;
  logic [4:0]                   w_crc5;
  logic [4:0]                   w_crc5_field;
  logic [7:0]                   w_byte;
  logic [7:0]                   w_bytes [C_report_length];

  // CRC5 over the 11 token bits, LSB first, poly x^5+x^2+1, init all ones.
  function automatic logic [4:0] f_crc5(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b00101;
    end
    return c;
  endfunction

  // Reflected CRC16 (0xA001) advanced by one byte, LSB first.
  function automatic logic [15:0] f_crc16(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Split the active buffer into addressable payload bytes.
  genvar gi;
  generate
    for (gi = 0; gi < C_report_length; gi++) begin : g_byte
      assign w_bytes[gi] = r_active[gi*8 +: 8];
    end
  endgenerate

  assign w_byte = w_bytes[r_idx];

  // The CRC field travels MSB first in b2[3..7], so b2[3] carries ~crc[4].
  assign w_crc5       = f_crc5({r_b2[2:0], r_b1[7], r_b1[6:0]});
  assign w_crc5_field = ~{r_b2[3], r_b2[4], r_b2[5], r_b2[6], r_b2[7]};
  assign w_tok_ok     = (w_crc5 == w_crc5_field) &&
                        (r_b1[6:0] == dev_addr) &&
                        ({r_b2[2:0], r_b1[7]} == C_EP);

  // Staging moves to the active buffer only in a quiet IDLE cycle; a strobe
  // in the same cycle wins and the copy waits one more cycle.
  assign w_copy = (r_state == S_IDLE) && !r_pending && r_staged && !report_strobe;

  assign toggle  = r_toggle;
  assign pending = r_pending;
  assign sent    = w_ack_done;

  // Next-state decode for token reception, response and handshake wait.
  always_comb begin
    w_state_next = r_state;
    w_ack_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_active && rx_error) begin
          w_state_next = S_SKIP;
        end else if (rx_active && rx_valid) begin
          if (rx_data[7:4] != ~rx_data[3:0]) w_state_next = S_SKIP;
          else if (rx_data == C_PID_IN)      w_state_next = S_TOK1;
          else                               w_state_next = S_SKIP;
        end
      end
      S_TOK1: begin
        if (rx_error)        w_state_next = S_SKIP;
        else if (rx_valid)   w_state_next = S_TOK2;
        else if (!rx_active) w_state_next = S_IDLE;
      end
      S_TOK2: begin
        if (rx_error)        w_state_next = S_SKIP;
        else if (rx_valid)   w_state_next = S_TOK_END;
        else if (!rx_active) w_state_next = S_IDLE;
      end
      S_TOK_END: begin
        if (rx_error || rx_valid) begin
          w_state_next = S_SKIP;
        end else if (!rx_active) begin
          if (!w_tok_ok)      w_state_next = S_IDLE;
          else if (r_pending) w_state_next = S_TX_PID;
          else                w_state_next = S_TX_HS;
        end
      end
      S_SKIP: begin
        if (!rx_active) w_state_next = S_IDLE;
      end
      S_TX_PID: begin
        if (tx_ready) w_state_next = S_TX_DATA;
      end
      S_TX_DATA: begin
        if (tx_ready && (r_idx == C_LAST_IDX)) w_state_next = S_TX_CRCL;
      end
      S_TX_CRCL: begin
        if (tx_ready) w_state_next = S_TX_CRCH;
      end
      S_TX_CRCH: begin
        if (tx_ready) w_state_next = S_WAIT_ACK;
      end
      S_TX_HS: begin
        if (tx_ready) w_state_next = S_IDLE;
      end
      S_WAIT_ACK: begin
        if (rx_active && rx_error) begin
          w_state_next = S_SKIP;
        end else if (rx_active && rx_valid) begin
          w_state_next = (rx_data == C_PID_ACK) ? S_ACK_END : S_SKIP;
        end else if (!rx_active && (r_cnt <= W_CNT'(1))) begin
          w_state_next = S_IDLE;
        end
      end
      S_ACK_END: begin
        if (rx_error || rx_valid) begin
          w_state_next = S_SKIP;
        end else if (!rx_active) begin
          w_state_next = S_IDLE;
          w_ack_done   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Transmit byte mux; data stays stable for as long as the state holds.
  always_comb begin
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      S_TX_PID: begin
        tx_valid = 1'b1;
        tx_data  = r_toggle ? C_PID_DATA1 : C_PID_DATA0;
      end
      S_TX_DATA: begin
        tx_valid = 1'b1;
        tx_data  = w_byte;
      end
      S_TX_CRCL: begin
        tx_valid = 1'b1;
        tx_data  = ~r_crc[7:0];
      end
      S_TX_CRCH: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = ~r_crc[15:8];
      end
      S_TX_HS: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = C_PID_NAK;
      end
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  // State register, token capture, payload counter, CRC and ACK timer.
  always_ff @(posedge clk) begin
    if (bus_reset) begin
      r_state <= S_IDLE;
      r_b1    <= 8'h00;
      r_b2    <= 8'h00;
      r_idx   <= '0;
      r_crc   <= 16'hFFFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_TOK1) && rx_valid) r_b1 <= rx_data;
      if ((r_state == S_TOK2) && rx_valid) r_b2 <= rx_data;

      if (r_state == S_TX_PID) begin
        r_idx <= '0;
        r_crc <= 16'hFFFF;
      end else if ((r_state == S_TX_DATA) && tx_ready) begin
        r_idx <= r_idx + W_IDX'(1);
        r_crc <= f_crc16(r_crc, w_byte);
      end

      if ((r_state == S_TX_CRCH) && tx_ready) begin
        r_cnt <= C_CNT_LOAD;
      end else if ((r_state == S_WAIT_ACK) && !rx_active && (r_cnt != '0)) begin
        r_cnt <= r_cnt - W_CNT'(1);
      end
    end
  end

  // Report buffers, pending flag and data toggle.
  always_ff @(posedge clk) begin
    if (bus_reset) begin
      r_stage   <= '0;
      r_staged  <= 1'b0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      if (report_strobe) begin
        r_stage  <= report;
        r_staged <= 1'b1;
      end
      if (w_copy) begin
        r_active  <= r_stage;
        r_staged  <= 1'b0;
        r_pending <= 1'b1;
      end
      if (w_ack_done) begin
        r_toggle  <= ~r_toggle;
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usbd_hid_report_responder.sv
// Directed bench for usbd_hid_report_responder: drives host packets on the
// byte-level RX side and checks the device responses on the TX side.
module tb_usbd_hid_report_responder;

  localparam int RL = 8;

  logic          clk = 1'b0;
  logic          bus_reset = 1'b1;
  logic [6:0]    dev_addr = 7'd0;
  logic [RL*8-1:0] report = '0;
  logic          report_strobe = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_active = 1'b0;
  logic          rx_error = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready = 1'b0;
  logic          toggle;
  logic          pending;
  logic          sent;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] got_q[$];
  logic       last_q[$];
  int         first_valid;

  usbd_hid_report_responder #(
    .C_report_length(RL),
    .C_endpoint(1),
    .C_ack_timeout(255)
  ) dut (
    .clk(clk),
    .bus_reset(bus_reset),
    .dev_addr(dev_addr),
    .report(report),
    .report_strobe(report_strobe),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_active(rx_active),
    .rx_error(rx_error),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .toggle(toggle),
    .pending(pending),
    .sent(sent)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc16_upd(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Host packet of n bytes with a gap cycle after each byte; rx_error optionally on the last byte.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int n, input logic err);
    rx_active = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      rx_data  = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
      rx_valid = 1'b1;
      rx_error = err && (i == n - 1);
      tick();
      rx_valid = 1'b0;
      rx_error = 1'b0;
      tick();
    end
    rx_active = 1'b0;
  endtask

  task automatic strobe(input logic [RL*8-1:0] r);
    report        = r;
    report_strobe = 1'b1;
    tick();
    report_strobe = 1'b0;
  endtask

  // Collect one device packet; rnd selects a random tx_ready pattern.
  task automatic recv_tx(input bit rnd);
    bit         done = 1'b0;
    bit         hold = 1'b0;
    logic [7:0] hold_d = 8'h00;
    int         cyc = 0;
    got_q.delete();
    last_q.delete();
    first_valid = -1;
    while (!done && cyc < 200) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (hold) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold_d});
      if (tx_valid && first_valid < 0) first_valid = cyc;
      hold   = tx_valid && !tx_ready;
      hold_d = tx_data;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        last_q.push_back(tx_last);
        if (tx_last) done = 1'b1;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    check("tx_done", 32'(done), 32'd1);
    @(negedge clk);
    check("tx_drop", 32'(tx_valid), 32'd0);
    tick();
  endtask

  task automatic expect_pkt(input string tag, input logic [7:0] pid, input logic [RL*8-1:0] rep);
    logic [7:0]  exp_q[$];
    logic [15:0] c;
    logic [15:0] r;
    c = 16'hFFFF;
    exp_q.push_back(pid);
    for (int i = 0; i < RL; i++) begin
      exp_q.push_back(rep[i*8 +: 8]);
      c = crc16_upd(c, rep[i*8 +: 8]);
    end
    exp_q.push_back(~c[7:0]);
    exp_q.push_back(~c[15:8]);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    check({tag, "_lat"}, 32'(first_valid), 32'd1);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == exp_q.size() - 1));
    end
    if (got_q.size() == exp_q.size()) begin
      r = 16'hFFFF;
      for (int i = 1; i < got_q.size(); i++) r = crc16_upd(r, got_q[i]);
      check({tag, "_residue"}, 32'(r), 32'hB001);
    end
  endtask

  task automatic expect_nak(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'd1);
    check({tag, "_lat"}, 32'(first_valid), 32'd1);
    if (got_q.size() > 0) begin
      check({tag, "_pid"}, 32'(got_q[0]), 32'h5A);
      check({tag, "_last"}, 32'(last_q[0]), 32'd1);
    end
  endtask

  task automatic no_tx(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
      tick();
    end
    check({tag, "_no_tx"}, 32'(seen), 32'd0);
  endtask

  task automatic do_ack(input string tag);
    send_pkt(8'hD2, 8'h00, 8'h00, 1, 1'b0);
    @(negedge clk);
    check({tag, "_sent"}, 32'(sent), 32'd1);
    tick();
    @(negedge clk);
    check({tag, "_sent_low"}, 32'(sent), 32'd0);
    tick();
  endtask

  task automatic send_in();
    send_pkt(8'h69, 8'h80, 8'hA0, 3, 1'b0);
  endtask

  initial begin
    int cnt;
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_sent", 32'(sent), 32'd0);
    check("rst_toggle", 32'(toggle), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    tick();
    bus_reset = 1'b0;
    tick();

    // IN with nothing staged -> NAK
    send_in();
    recv_tx(1'b0);
    expect_nak("nak1");
    @(negedge clk);
    check("nak1_toggle", 32'(toggle), 32'd0);
    check("nak1_pending", 32'(pending), 32'd0);
    tick();

    // First report -> DATA0, ACK flips toggle
    strobe(64'h0807060504030201);
    tick();
    @(negedge clk);
    check("r1_pending", 32'(pending), 32'd1);
    tick();
    send_in();
    recv_tx(1'b0);
    expect_pkt("r1", 8'hC3, 64'h0807060504030201);
    do_ack("r1");
    @(negedge clk);
    check("r1_toggle", 32'(toggle), 32'd1);
    check("r1_pending_clr", 32'(pending), 32'd0);
    tick();

    // Second report -> DATA1, no ACK, timeout, retransmit identical
    strobe(64'h1817161514131211);
    tick();
    send_in();
    recv_tx(1'b0);
    expect_pkt("r2", 8'h4B, 64'h1817161514131211);
    repeat (300) tick();
    @(negedge clk);
    check("r2_to_pending", 32'(pending), 32'd1);
    check("r2_to_toggle", 32'(toggle), 32'd1);
    tick();
    send_in();
    recv_tx(1'b0);
    expect_pkt("r2re", 8'h4B, 64'h1817161514131211);
    do_ack("r2");
    @(negedge clk);
    check("r2_toggle", 32'(toggle), 32'd0);
    tick();

    // Rejected tokens
    send_pkt(8'h69, 8'h80, 8'hA1, 3, 1'b0);
    no_tx("badcrc", 20);
    dev_addr = 7'd5;
    send_in();
    no_tx("badaddr", 20);
    dev_addr = 7'd0;
    send_pkt(8'h2D, 8'h00, 8'h10, 3, 1'b0);
    no_tx("setup", 20);
    send_pkt(8'h69, 8'h80, 8'hA0, 3, 1'b1);
    no_tx("rxerr", 20);
    send_in();
    recv_tx(1'b0);
    expect_nak("nak2");

    // Strobes during WAIT_ACK: last one wins for the next report
    strobe(64'h2827262524232221);
    tick();
    send_in();
    recv_tx(1'b0);
    expect_pkt("r3", 8'hC3, 64'h2827262524232221);
    strobe(64'hA8A7A6A5A4A3A2A1);
    strobe(64'hB8B7B6B5B4B3B2B1);
    @(negedge clk);
    check("r3_wait_pending", 32'(pending), 32'd1);
    tick();
    do_ack("r3");
    tick();
    send_in();
    recv_tx(1'b0);
    expect_pkt("rb", 8'h4B, 64'hB8B7B6B5B4B3B2B1);
    do_ack("rb");
    @(negedge clk);
    check("rb_toggle", 32'(toggle), 32'd0);
    tick();

    // Strobe coinciding with the IDLE copy delays pending by one cycle
    strobe(64'hC8C7C6C5C4C3C2C1);
    strobe(64'hD8D7D6D5D4D3D2D1);
    @(negedge clk);
    check("slip_pending0", 32'(pending), 32'd0);
    tick();
    @(negedge clk);
    check("slip_pending1", 32'(pending), 32'd1);
    tick();
    send_in();
    recv_tx(1'b1);
    expect_pkt("ry", 8'hC3, 64'hD8D7D6D5D4D3D2D1);
    do_ack("ry");
    @(negedge clk);
    check("ry_toggle", 32'(toggle), 32'd1);
    tick();

    // bus_reset in the middle of the payload
    strobe(64'hE8E7E6E5E4E3E2E1);
    tick();
    send_in();
    tx_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 4; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) cnt++;
      tick();
    end
    check("rz_progress", 32'(cnt), 32'd4);
    report        = 64'hF8F7F6F5F4F3F2F1;
    report_strobe = 1'b1;
    tick();
    report_strobe = 1'b0;
    tx_ready      = 1'b0;
    bus_reset     = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_last", 32'(tx_last), 32'd0);
    check("mid_rst_toggle", 32'(toggle), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    tick();
    bus_reset = 1'b0;
    no_tx("post_rst", 10);
    @(negedge clk);
    check("post_rst_pending", 32'(pending), 32'd0);
    tick();
    send_in();
    recv_tx(1'b0);
    expect_nak("nak3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usbd_hid_report_responder.md
Name: usbd_hid_report_responder

Overview:
- Device-side counterpart of usbh_host_hid: the transaction engine of a low/full-speed USB HID device on one interrupt IN endpoint.
- Sits between a byte-level device PHY/SIE (NRZI, bit-stuff and SYNC/EOP handled outside) and user logic that supplies HID reports.
- Answers host IN tokens with DATA0/DATA1 plus report plus CRC16, or NAK, and manages the data toggle from the host ACK.

Parameters:
- C_report_length, 8, report payload length in bytes (1..64).
- C_endpoint, 1, interrupt IN endpoint number (0..15).
- C_ack_timeout, 255, clk cycles to wait for the host handshake after the last TX byte.

Ports:
- clk  in  1  USB clock (6 MHz low-speed / 48 MHz full-speed), same domain as the PHY byte interface.
- bus_reset  in  1  synchronous, active-high reset.
- dev_addr  in  7  current device address.
- report  in  C_report_length*8  new report; byte 0 is report[7:0].
- report_strobe  in  1  one-cycle pulse that captures report.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_active  in  1  high from SYNC to EOP of a received packet.
- rx_error  in  1  PHY error (stuff/PID/EOP) in the current packet.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  tx_data is the final byte of the packet.
- tx_ready  in  1  PHY accepts tx_data at this rising edge.
- toggle  out  1  data PID for the next new report: 0 = DATA0, 1 = DATA1.
- pending  out  1  active buffer holds a report not yet ACKed.
- sent  out  1  one-cycle pulse when the host ACKs a report.

Behaviour:
- Reset: state IDLE. tx_valid, tx_last, sent, toggle, pending = 0; staged = 0; tx_data = 0x00. Reset mid-packet aborts immediately and drives no further bytes.
- Buffers:
  - report_strobe always writes the staging register and sets staged.
  - Staging moves to the active buffer (staged := 0, pending := 1) in any IDLE cycle with pending = 0 and staged = 1 and no strobe that cycle; if a strobe coincides, the copy slips one cycle.
  - A retransmission always resends the unchanged active buffer.
- PID check: first rx byte of a packet must satisfy pid[7:4] == ~pid[3:0]; on failure go to SKIP.
- RX states:
  - IDLE -> PID on the first rx_valid while rx_active.
  - PID 0x69 (IN) -> TOK1; any other PID -> SKIP.
  - TOK1: b1. TOK2: b2.
  - addr = b1[6:0]; endp = {b2[2:0], b1[7]}.
  - CRC5: poly 00101, init 11111, fed addr[0..6] then endp[0..3]; ~crc sent MSB-first must equal b2[3..7] in bit order. Example: addr 0, ep1 -> 0x80 0xA0.
  - TOK_END: rx_active must fall with no further rx_valid.
  - Token accepted only if CRC ok, addr == dev_addr, endp == C_endpoint and no rx_error; otherwise -> SKIP or IDLE.
- SKIP: wait until rx_active = 0, then IDLE.
- rx_error in any RX state: go to SKIP.
- Response starts the cycle after rx_active falls on an accepted token:
  - pending = 1: TX_PID (0xC3 if toggle = 0, 0x4B if 1) -> TX_DATA (bytes 0..C_report_length-1) -> TX_CRCL -> TX_CRCH (tx_last = 1) -> WAIT_ACK.
  - pending = 0: TX_HS sends 0x5A (NAK) with tx_last = 1, then IDLE.
- CRC16: reflected poly 0xA001, init 0xFFFF, over payload bytes LSB-first; transmit ~crc, low byte first.
- TX handshake:
  - tx_valid and tx_data stay stable until sampled with tx_ready = 1.
  - The next byte is presented the following cycle; no gap bubbles are required.
  - tx_valid drops the cycle after the last byte is accepted.
- WAIT_ACK:
  - A counter is loaded with C_ack_timeout on the last byte accept and decrements while rx_active = 0.
  - A 1-byte packet 0xD2 (ACK) without rx_error: toggle flips, pending := 0, sent pulses in the cycle rx_active falls, then IDLE.
  - Any other packet: SKIP, with no toggle change and pending kept.
  - Counter reaching 0 with no packet: IDLE, with no toggle change and pending kept, so the next IN retries with the same PID and data.
- Tokens arriving during TX are not possible on a half-duplex bus; any rx_valid during TX states is ignored.

Test Plan:
- Reset, dev_addr = 0, no strobe; send 69 80 A0 -> single byte 0x5A with tx_last = 1; toggle = 0, pending = 0.
- Strobe report 01..08; IN 69 80 A0 -> C3, 01..08, CRC low/high per model, tx_last only on CRC high; reply D2 -> sent pulse, toggle = 1, pending = 0.
- Second report then IN -> PID 0x4B; no ACK for 255 cycles -> next IN resends 0x4B with identical bytes; ACK -> toggle = 0.
- Bad tokens 69 80 A1 (CRC), dev_addr = 5 with 69 80 A0, and 2D 00 10 (SETUP) -> no tx_valid ever.
- Strobe A during WAIT_ACK, then strobe B -> after ACK the next DATA carries B; strobe in the same cycle as the IDLE copy delays pending by one cycle.
- tx_ready toggled 1/0 randomly -> byte order unchanged, no drops or duplicates; bus_reset mid-TX_DATA -> tx_valid = 0 next cycle, toggle = 0, pending = 0.
